uart_rx_frame: RTL

Parametrised UART frame receiver for the host serial link. It supports 5–9 data bits, optional even/odd parity, 1 or 2 stop bits and 3-point majority sampling. Each received frame is presented with per-frame error flags through a one-entry valid/ready holding register. It sits between the board RX pin and the command decoder.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_bit_sampler.sv | 51 +++++
 rtl/uart_rx_frame.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the UART frame receiver
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
    return clk_hz / bit_rate;
  endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// rtl/uart_bit_sampler.sv - per-bit cycle counter with 3-point majority sampling
module uart_bit_sampler #(
  parameter int CPB = 234
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic line,
  output logic bit_done,
  output logic bit_value,
  output logic bit_wrap
);

  localparam int H     = CPB / 2;
  localparam int CNT_W = $clog2(CPB);
  localparam logic [CNT_W-1:0] CNT_EARLY  = CNT_W'(H - 1);
  localparam logic [CNT_W-1:0] CNT_MID    = CNT_W'(H);
  localparam logic [CNT_W-1:0] CNT_DECIDE = CNT_W'(H + 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CPB - 1);

  logic [CNT_W-1:0] cnt;
  logic             samp_early;
  logic             samp_mid;

  // Bit-period counter; held at zero while idle so a new start bit begins at count 0
  always_ff @(posedge clk) begin
    if (reset || !run) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Capture the two early samples; the third is the live line at the decision count
  always_ff @(posedge clk) begin
    if (reset) begin
      samp_early <= 1'b1;
      samp_mid   <= 1'b1;
    end else begin
      if (cnt == CNT_EARLY) samp_early <= line;
      if (cnt == CNT_MID)   samp_mid   <= line;
    end
  end

  assign bit_done  = run && (cnt == CNT_DECIDE);
  assign bit_value = (samp_early & samp_mid) | (samp_early & line) | (samp_mid & line);
  assign bit_wrap  = run && (cnt == CNT_LAST);

endmodule

// File: rtl/uart_rx_frame.sv
// rtl/uart_rx_frame.sv - UART frame receiver with error flags and a one-entry holding register
module uart_rx_frame import uart_pkg::*; #(
  parameter int CLK_HZ    = 27_000_000,
  parameter int BIT_RATE  = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 uart_rxd,
  input  logic                 rx_en,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_break,
  output logic                 rx_overrun
);

  localparam int      CPB       = cycles_per_bit(CLK_HZ, BIT_RATE);
  localparam parity_e PAR_MODE  = parity_e'(PARITY);
  localparam int      BIT_CNT_W = $clog2(DATA_BITS + 1);

  if (CPB < 8) begin : g_bad_cpb
    $error("uart_rx_frame: fewer than 8 clocks per bit");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_rx_frame: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_rx_frame: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_rx_frame: STOP_BITS must be 1 or 2");
  end

  logic                 sync_q1;
  logic                 sync_q2;
  rx_state_e            state;
  logic [DATA_BITS-1:0] shift_q;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic                 stop_cnt;
  logic                 par_err_q;
  logic                 frm_err_q;
  logic                 all_zero_q;
  logic                 wait_high;
  logic                 bit_done;
  logic                 bit_value;
  logic                 bit_wrap;
  logic                 last_stop;
  logic                 frame_done;
  logic                 frm_err_fin;
  logic                 brk_fin;
  logic                 par_exp;

  // Two-flop synchroniser; a disabled receiver sees an idle line
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
    end else begin
      sync_q1 <= uart_rxd | ~rx_en;
      sync_q2 <= sync_q1;
    end
  end

  uart_bit_sampler #(.CPB(CPB)) u_sampler (
    .clk       (clk),
    .reset     (reset),
    .run       (state != RX_IDLE),
    .line      (sync_q2),
    .bit_done  (bit_done),
    .bit_value (bit_value),
    .bit_wrap  (bit_wrap)
  );

  assign last_stop   = (STOP_BITS == 1) || stop_cnt;
  assign frame_done  = rx_en && (state == RX_STOP) && bit_done && last_stop;
  assign frm_err_fin = frm_err_q | ~bit_value;
  // Break looks at the first stop bit only
  assign brk_fin     = stop_cnt ? all_zero_q : (all_zero_q & ~bit_value);
  assign par_exp     = (PAR_MODE == PAR_ODD) ? ~(^shift_q) : (^shift_q);

  // Frame FSM: start validation, payload shift, parity check, stop sampling
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RX_IDLE;
      shift_q    <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      all_zero_q <= 1'b1;
      wait_high  <= 1'b0;
    end else if (!rx_en) begin
      state     <= RX_IDLE;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
      wait_high <= 1'b0;
    end else begin
      case (state)
        RX_IDLE: begin
          if (sync_q2) wait_high <= 1'b0;
          // After a low stop bit the line must return high before a new start is trusted
          if (!sync_q2 && !wait_high) begin
            state      <= RX_START;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            all_zero_q <= 1'b1;
          end
        end
        RX_START: begin
          if (bit_done && bit_value) state <= RX_IDLE;
          else if (bit_wrap)         state <= RX_DATA;
        end
        RX_DATA: begin
          if (bit_done) begin
            shift_q    <= {bit_value, shift_q[DATA_BITS-1:1]};
            bit_cnt    <= bit_cnt + 1'b1;
            all_zero_q <= all_zero_q & ~bit_value;
          end
          if (bit_wrap && bit_cnt == BIT_CNT_W'(DATA_BITS)) begin
            bit_cnt <= '0;
            state   <= (PAR_MODE == PAR_NONE) ? RX_STOP : RX_PARITY;
          end
        end
        RX_PARITY: begin
          if (bit_done) begin
            par_err_q  <= (bit_value != par_exp);
            all_zero_q <= all_zero_q & ~bit_value;
          end
          if (bit_wrap) state <= RX_STOP;
        end
        RX_STOP: begin
          if (bit_done) begin
            frm_err_q <= frm_err_fin;
            if (!stop_cnt) all_zero_q <= all_zero_q & ~bit_value;
            if (last_stop) begin
              state     <= RX_IDLE;
              wait_high <= ~bit_value;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  // Holding register: load on completion when empty or being drained, else flag overrun
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_break      <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      rx_overrun <= 1'b0;
      if (frame_done) begin
        if (!rx_valid || rx_ready) begin
          rx_data       <= shift_q;
          rx_valid      <= 1'b1;
          rx_parity_err <= par_err_q;
          rx_frame_err  <= frm_err_fin;
          rx_break      <= brk_fin;
        end else begin
          rx_overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
